// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, opcodes, op classes and one-hot op bit positions
package alu_seq_pkg;
  typedef enum logic [2:0] {IDLE, T3, T4, T5, T6} state_t;
  typedef enum logic [1:0] {BINARY, UNARY, WIDE, ILLEGAL} op_class_t;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_ROR  = 5'b00111;
  localparam logic [4:0] OPC_ROL  = 5'b01000;
  localparam logic [4:0] OPC_SHR  = 5'b01001;
  localparam logic [4:0] OPC_SHRA = 5'b01010;
  localparam logic [4:0] OPC_SHL  = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_NEG  = 2;
  localparam int OP_NOT  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_ADD  = 5;
  localparam int OP_MUL  = 6;
  localparam int OP_ROR  = 7;
  localparam int OP_ROL  = 8;
  localparam int OP_DIV  = 9;
  localparam int OP_SHR  = 10;
  localparam int OP_SHL  = 11;
  localparam int OP_SHRA = 12;
endpackage

// File: rtl/alu_seq_op_decode.sv
// alu_op_decode: opcode to operation class and one-hot ALU op vector
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [4:0]  opcode,
  output op_class_t   op_class,
  output logic [12:0] ops
);
  always_comb begin
    op_class = BINARY;
    ops = '0;
    case (opcode)
      OPC_ADD:  ops[OP_ADD] = 1'b1;
      OPC_SUB:  ops[OP_SUB] = 1'b1;
      OPC_AND:  ops[OP_AND] = 1'b1;
      OPC_OR:   ops[OP_OR] = 1'b1;
      OPC_ROR:  ops[OP_ROR] = 1'b1;
      OPC_ROL:  ops[OP_ROL] = 1'b1;
      OPC_SHR:  ops[OP_SHR] = 1'b1;
      OPC_SHRA: ops[OP_SHRA] = 1'b1;
      OPC_SHL:  ops[OP_SHL] = 1'b1;
      OPC_MUL:  begin op_class = WIDE; ops[OP_MUL] = 1'b1; end
      OPC_DIV:  begin op_class = WIDE; ops[OP_DIV] = 1'b1; end
      OPC_NEG:  begin op_class = UNARY; ops[OP_NEG] = 1'b1; end
      OPC_NOT:  begin op_class = UNARY; ops[OP_NOT] = 1'b1; end
      default:  op_class = ILLEGAL;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps one ALU instruction through T3..T6 driving datapath strobes
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       issue_valid,
  input  logic [4:0] issue_opcode,
  output logic       issue_ready,
  input  logic       hold,
  output logic       gra,
  output logic       grb,
  output logic       grc,
  output logic       r_out,
  output logic       r_in,
  output logic       y_in,
  output logic       z_in,
  output logic       zlo_out,
  output logic       zhi_out,
  output logic       lo_in,
  output logic       hi_in,
  output logic       op_and,
  output logic       op_or,
  output logic       op_neg,
  output logic       op_not,
  output logic       op_sub,
  output logic       op_add,
  output logic       op_mul,
  output logic       op_ror,
  output logic       op_rol,
  output logic       op_div,
  output logic       op_shr,
  output logic       op_shl,
  output logic       op_shra,
  output logic       done,
  output logic       illegal
);
  state_t state, nxt;
  op_class_t cls;
  logic [4:0] op_q, dec_opcode;
  logic [12:0] ops, op_vec;
  logic ready_q, accept, wide, un;
  assign issue_ready = ready_q && !hold;
  assign accept = issue_valid && issue_ready;
  assign dec_opcode = accept ? issue_opcode : op_q;
  alu_op_decode u_dec (.opcode(dec_opcode), .op_class(cls), .ops(ops));
  assign wide = cls == WIDE;
  assign un = cls == UNARY;
  assign nxt = state == IDLE ? ((accept && cls != ILLEGAL) ? T3 : IDLE) :
               state == T3 ? T4 :
               state == T4 ? T5 :
               (state == T5 && wide) ? T6 : IDLE;
  assign {op_shra, op_shl, op_shr, op_div, op_rol, op_ror, op_mul,
          op_add, op_sub, op_not, op_neg, op_or, op_and} = op_vec;
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      op_q <= '0;
      ready_q <= 1'b1;
      op_vec <= '0;
      {gra, grb, grc, r_out, r_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, done, illegal} <= '0;
    end else if (!hold) begin
      state <= nxt;
      op_q <= accept ? issue_opcode : op_q;
      ready_q <= nxt == IDLE;
      illegal <= accept && cls == ILLEGAL;
      gra <= (nxt == T3 && wide) || (nxt == T5 && !wide);
      grb <= (nxt == T3 && cls == BINARY) || (nxt == T4 && cls != BINARY);
      grc <= nxt == T4 && cls == BINARY;
      r_out <= (nxt == T3 && !un) || nxt == T4;
      y_in <= nxt == T3 && !un;
      z_in <= nxt == T4;
      op_vec <= nxt == T4 ? ops : '0;
      zlo_out <= nxt == T5;
      lo_in <= nxt == T5 && wide;
      r_in <= nxt == T5 && !wide;
      zhi_out <= nxt == T6;
      hi_in <= nxt == T6;
      done <= (nxt == T5 && !wide) || nxt == T6;
    end
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer that drives the ALU's one-hot operation lines and the datapath register strobes around it. It accepts one decoded ALU-class instruction per handshake and steps through T3..T5, plus T6 for MUL/DIV. In those steps it loads Y, asserts exactly one ALU operation while Z captures, then writes Z back to Ra, or to LO/HI. It sits between instruction fetch/decode and the bus-based datapath, which contains the ALU, Y, Z (ZHi/ZLo), HI, LO and the register file.

## Interface
- No parameters; opcode encodings live in the shared package.
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction available
- issue_opcode  in  5  opcode field IR[31:27]
- issue_ready  out  1  high only in IDLE
- hold  in  1  freezes state and all registered outputs for that cycle
- gra, grb, grc  out  1 each  select the Ra/Rb/Rc field for the register file
- r_out, r_in  out  1 each  selected register drives bus / loads from bus
- y_in, z_in, zlo_out, zhi_out, lo_in, hi_in  out  1 each  datapath strobes
- op_and, op_or, op_neg, op_not, op_sub, op_add, op_mul, op_ror, op_rol, op_div, op_shr, op_shl, op_shra  out  1 each  ALU one-hot op lines
- done  out  1  one-cycle pulse in the final step
- illegal  out  1  one-cycle pulse when a non-ALU opcode is accepted

## Operation
- States: IDLE, T3, T4, T5, T6. Accept when issue_valid && issue_ready; the opcode is latched into op_q at accept.
- IDLE -> T3 on a legal accept. On an illegal accept, illegal pulses the next cycle and the state stays IDLE.
- Binary ops (ADD SUB AND OR ROR ROL SHR SHL SHRA):
  - T3: grb, r_out, y_in.
  - T4: grc, r_out, op line for op_q, z_in.
  - T5: zlo_out, gra, r_in, done; then IDLE.
- Unary ops (NEG NOT):
  - T3: no strobes.
  - T4: grb, r_out, op line, z_in.
  - T5: as for binary ops.
- MUL/DIV:
  - T3: gra, r_out, y_in.
  - T4: grb, r_out, op_mul or op_div, z_in.
  - T5: zlo_out, lo_in.
  - T6: zhi_out, hi_in, done; then IDLE.
- Invariants:
  - At most one op_* line is high, and only in T4.
  - All strobes are zero in IDLE.
  - Exactly one of gra/grb/grc is high whenever r_out or r_in is high.
- hold=1 freezes the current state and outputs. An accept cannot occur while hold=1, because issue_ready is forced low.
- clear in any state: next cycle is IDLE with all outputs 0. No writeback occurs, and pending done/illegal pulses are dropped.

## Timing
- All outputs are registered and decoded from the next state, so strobes are valid for the entire state cycle.
- Reset values: issue_ready=1; every other output 0.
- Latency from the accept edge:
  - T3 strobes appear 1 cycle after the accept edge.
  - done appears 3 cycles after the accept edge for 3-step ops, 4 cycles for MUL/DIV.
  - Each cycle of hold adds 1 cycle.
- Throughput: issue_ready returns high the cycle after done. Back-to-back instructions therefore take 4 or 5 cycles each.
- issue_valid while busy is ignored. Upstream must hold valid and opcode until issue_ready.

## Structure
- Package alu_seq_pkg holds:
  - State enum.
  - Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
  - An op-class enum: BINARY, UNARY, WIDE, ILLEGAL.
- One sub-module, alu_op_decode: combinational opcode -> {class, 13-bit one-hot op vector}. The sequencer gates the op vector onto op_* in T4 only.

## Test plan
- Reset and idle:
  - Stimulus: clear held 2 cycles, then released.
  - Response: issue_ready=1 and every other output 0. With issue_valid=0 for 5 cycles, no strobes toggle.
- ADD:
  - Stimulus: issue opcode 00011.
  - Response, per cycle after accept:
    - T3: grb, r_out, y_in.
    - T4: grc, r_out, op_add, z_in.
    - T5: zlo_out, gra, r_in, done.
    - issue_ready=1 on the 4th cycle.
- MUL then DIV back-to-back:
  - Stimulus: issue opcode 01111 followed by 10000.
  - Response: op_mul in T4, lo_in in T5, hi_in with done in T6. The DIV is accepted the cycle ready returns, with op_div in its T4.
- NOT:
  - Stimulus: issue opcode 10010.
  - Response: no strobes in T3. T4 has grb, r_out, op_not, z_in. Across all cycles op_* is one-hot or zero.
- Illegal, busy and hold:
  - Stimulus: opcode 00000.
  - Response: illegal pulses for 1 cycle, state stays IDLE, no strobes.
  - Stimulus: issue_valid held during a running SUB.
  - Response: the second instruction is not accepted until ready.
  - Stimulus: hold=1 for 3 cycles during T4.
  - Response: T4 strobes persist 4 cycles; done is delayed by 3.
- Reset mid-operation:
  - Stimulus: clear asserted during T5 of a MUL.
  - Response: next cycle is IDLE with all strobes 0, and hi_in and done never assert.
